// File: rtl/fetch_unit.sv
// Instruction fetch stage: samples the selected PC, issues one outstanding
// instruction-memory read and holds the result in a one-entry buffer toward decode.
//
// state | meaning
// IDLE  | no request outstanding; waits for empty/draining buffer to launch a fetch
// REQ   | request held on imem_req/imem_addr until imem_ack
module fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  i_pc_in,
  output logic [ADDR_W-1:0]  o_pc_inc,
  input  logic               i_flush,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_ack,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic               o_if_valid,
  input  logic               i_if_ready,
  output logic [INSTR_W-1:0] o_if_instr,
  output logic [ADDR_W-1:0]  o_if_pc
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t               r_state;
  logic [ADDR_W-1:0]    r_fetch_addr;
  logic                 r_drop;
  logic                 r_imem_req;
  logic                 r_if_valid;
  logic [INSTR_W-1:0]   r_if_instr;
  logic [ADDR_W-1:0]    r_if_pc;
  logic                 w_buf_free;

  assign w_buf_free = !r_if_valid || i_if_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_fetch_addr <= '0;
      r_drop       <= 1'b0;
      r_imem_req   <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= '0;
      r_if_pc      <= '0;
    end else begin
      if (r_if_valid && i_if_ready)
        r_if_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          if (!i_flush && w_buf_free) begin
            r_state      <= REQ;
            r_fetch_addr <= i_pc_in;
            r_imem_req   <= 1'b1;
          end
        end
        REQ: begin
          if (i_imem_ack) begin
            if (!r_drop && !i_flush) begin
              r_if_instr <= i_imem_rdata;
              r_if_pc    <= r_fetch_addr;
              r_if_valid <= 1'b1;
            end
            r_drop     <= 1'b0;
            r_imem_req <= 1'b0;
            r_state    <= IDLE;
          end else if (i_flush) begin
            // request stays on the bus; its data is discarded when it returns
            r_drop <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (i_flush)
        r_if_valid <= 1'b0;
    end
  end

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_fetch_addr;
  assign o_pc_inc    = r_fetch_addr + 1'b1;
  assign o_if_valid  = r_if_valid;
  assign o_if_instr  = r_if_instr;
  assign o_if_pc     = r_if_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, zero-wait and wait-state fetches,
// backpressure, flush of an in-flight read, address wrap and async reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc_in;
  logic [7:0]  pc_inc;
  logic        flush;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [15:0] if_instr;
  logic [7:0]  if_pc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pc_in      (pc_in),
    .o_pc_inc     (pc_inc),
    .i_flush      (flush),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .o_if_valid   (if_valid),
    .i_if_ready   (if_ready),
    .o_if_instr   (if_instr),
    .o_if_pc      (if_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc_in = 8'h10; flush = 1'b0; imem_ack = 1'b0;
    imem_rdata = 16'h0; if_ready = 1'b0;
    tick(); tick();
    chk("rst_req",    imem_req, 0);
    chk("rst_valid",  if_valid, 0);
    chk("rst_pcinc",  pc_inc, 8'h01);
    chk("rst_addr",   imem_addr, 8'h00);
    chk("rst_ifpc",   if_pc, 8'h00);
    chk("rst_instr",  if_instr, 16'h0);
    rst = 1'b0;

    // zero-wait fetch: cycle 0 IDLE, cycle 1 REQ+ack, cycle 2 valid
    tick();
    chk("zw_req",   imem_req, 1);
    chk("zw_addr",  imem_addr, 8'h10);
    chk("zw_pcinc", pc_inc, 8'h11);
    imem_ack = 1'b1; imem_rdata = 16'hA5A5;
    tick();
    imem_ack = 1'b0; imem_rdata = 16'h0;
    chk("zw_valid", if_valid, 1);
    chk("zw_instr", if_instr, 16'hA5A5);
    chk("zw_ifpc",  if_pc, 8'h10);
    chk("zw_reqlo", imem_req, 0);

    // backpressure: no new request, outputs stable
    pc_in = 8'h20;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_req",   imem_req, 0);
      chk("bp_valid", if_valid, 1);
      chk("bp_instr", if_instr, 16'hA5A5);
      chk("bp_ifpc",  if_pc, 8'h10);
    end
    if_ready = 1'b1;
    tick();
    chk("bp_rel_req",   imem_req, 1);
    chk("bp_rel_valid", if_valid, 0);

    // three wait states: request held four cycles
    for (int i = 0; i < 3; i++) begin
      chk("ws_req",  imem_req, 1);
      chk("ws_addr", imem_addr, 8'h20);
      tick();
    end
    chk("ws_req4",  imem_req, 1);
    chk("ws_addr4", imem_addr, 8'h20);
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    tick();
    imem_ack = 1'b0;
    chk("ws_valid", if_valid, 1);
    chk("ws_instr", if_instr, 16'h1234);
    chk("ws_ifpc",  if_pc, 8'h20);

    // flush one cycle before ack: 0xDEAD must be discarded
    pc_in = 8'h30;
    tick();
    chk("fl_req",   imem_req, 1);
    chk("fl_addr",  imem_addr, 8'h30);
    chk("fl_cons",  if_valid, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_hold",  imem_req, 1);
    chk("fl_haddr", imem_addr, 8'h30);
    imem_ack = 1'b1; imem_rdata = 16'hDEAD; pc_in = 8'h40;
    tick();
    imem_ack = 1'b0;
    chk("fl_valid", if_valid, 0);
    chk("fl_instr", if_instr, 16'h1234);
    chk("fl_idle",  imem_req, 0);
    tick();
    chk("fl_nreq",  imem_req, 1);
    chk("fl_naddr", imem_addr, 8'h40);
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    tick();
    imem_ack = 1'b0;
    chk("fl_nvalid", if_valid, 1);
    chk("fl_ninstr", if_instr, 16'hBEEF);
    chk("fl_nifpc",  if_pc, 8'h40);

    // wrap at 0xFF
    pc_in = 8'hFF;
    tick();
    chk("wr_addr",  imem_addr, 8'hFF);
    chk("wr_pcinc", pc_inc, 8'h00);
    imem_ack = 1'b1; imem_rdata = 16'h00FF; pc_in = 8'h00;
    tick();
    imem_ack = 1'b0;
    chk("wr_ifpc",  if_pc, 8'hFF);
    chk("wr_instr", if_instr, 16'h00FF);
    tick();
    chk("wr_naddr", imem_addr, 8'h00);
    chk("wr_npcinc", pc_inc, 8'h01);

    // load a buffer entry, then reset mid-REQ
    if_ready = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h7777;
    tick();
    imem_ack = 1'b0;
    chk("mr_valid", if_valid, 1);
    chk("mr_instr", if_instr, 16'h7777);
    if_ready = 1'b1; pc_in = 8'h55;
    tick();
    chk("mr_req",   imem_req, 1);
    chk("mr_addr",  imem_addr, 8'h55);
    chk("mr_pcinc", pc_inc, 8'h56);
    #2 rst = 1'b1; imem_ack = 1'b1;
    #1;
    chk("ar_req",   imem_req, 0);
    chk("ar_valid", if_valid, 0);
    chk("ar_ifpc",  if_pc, 8'h00);
    chk("ar_instr", if_instr, 16'h0);
    chk("ar_pcinc", pc_inc, 8'h01);
    tick();
    chk("ar_ackign", if_valid, 0);
    imem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
